// File: rtl/mandel_pkg.sv
// Shared types and defaults for the Mandelbrot pixel dispatcher.
// Fixed-point values are signed 4.23 (27 bits). Iteration counts are 13 bits.
package mandel_pkg;

    localparam int FIX_W     = 27;
    localparam int FRAC_W    = 23;
    localparam int ITER_W    = 13;
    localparam int ADDR_W    = 19;
    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

    typedef logic signed [FIX_W-1:0] fix_t;
    typedef logic [ITER_W-1:0]       iter_t;
    typedef logic [ADDR_W-1:0]       addr_t;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        EMIT,
        ADVANCE
    } state_t;

endpackage

// File: rtl/coord_stepper.sv
// Raster walker: x/y counters, cr/ci accumulators and linear pixel address.
// Coordinates advance by addition only; accumulators wrap in 27 bits.
module coord_stepper
    import mandel_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  logic  step,
    input  fix_t  x_start,
    input  fix_t  y_start,
    input  fix_t  dx,
    input  fix_t  dy,
    output fix_t  cr,
    output fix_t  ci,
    output addr_t pix_addr,
    output logic  last
);

    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    fix_t          x0_q;
    fix_t          dx_q;
    fix_t          dy_q;
    logic          x_end;

    assign x_end = (x == X_LAST);
    assign last  = x_end && (y == Y_LAST);

    // Load frame origin and steps on start, then walk the raster one pixel per step.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            x        <= '0;
            y        <= '0;
            cr       <= '0;
            ci       <= '0;
            pix_addr <= '0;
            x0_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
        end else if (load) begin
            x        <= '0;
            y        <= '0;
            cr       <= x_start;
            ci       <= y_start;
            pix_addr <= '0;
            x0_q     <= x_start;
            dx_q     <= dx;
            dy_q     <= dy;
        end else if (step) begin
            pix_addr <= pix_addr + addr_t'(1);
            if (!x_end) begin
                x  <= x + XW'(1);
                cr <= cr + dx_q;
            end else begin
                x  <= '0;
                cr <= x0_q;
                y  <= y + YW'(1);
                ci <= ci - dy_q;
            end
        end
    end

endmodule

// File: rtl/pixel_dispatcher.sv
// Pixel dispatcher: launches the iteration solver once per pixel, captures
// its count and hands (address, count) to the VGA writer with valid/ready.
// Optional macro PIXEL_DISPATCH_PERF_EN adds a frame_cycles counter output.
module pixel_dispatcher
    import mandel_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  fix_t        x_start,
    input  fix_t        y_start,
    input  fix_t        dx,
    input  fix_t        dy,
    output logic        solver_reset,
    output fix_t        cr,
    output fix_t        ci,
    input  iter_t       solver_iter,
    input  logic        solver_done,
    output logic        pix_valid,
    input  logic        pix_ready,
    output addr_t       pix_addr,
    output iter_t       pix_iter,
    output logic        busy,
`ifdef PIXEL_DISPATCH_PERF_EN
    output logic [31:0] frame_cycles,
`endif
    output logic        frame_done
);

    state_t state;
    state_t state_next;
    logic   wait_first;
    logic   load;
    logic   step;
    logic   capture;
    logic   last;

    coord_stepper #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_stepper (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .x_start  (x_start),
        .y_start  (y_start),
        .dx       (dx),
        .dy       (dy),
        .cr       (cr),
        .ci       (ci),
        .pix_addr (pix_addr),
        .last     (last)
    );

    // State register, first-WAIT-cycle flag and captured iteration count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wait_first <= 1'b0;
            pix_iter   <= '0;
        end else begin
            state      <= state_next;
            wait_first <= (state == LAUNCH);
            if (capture) begin
                pix_iter <= solver_iter;
            end
        end
    end

    // Next-state logic and Moore/Mealy strobes; solver done is ignored on the first WAIT cycle.
    always_comb begin
        // NOTE: every output gets a default first so no branch can infer a latch.
        state_next   = state;
        solver_reset = 1'b0;
        pix_valid    = 1'b0;
        busy         = 1'b1;
        frame_done   = 1'b0;
        load         = 1'b0;
        step         = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                busy         = 1'b0;
                solver_reset = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                solver_reset = 1'b1;
                state_next   = WAIT;
            end
            WAIT: begin
                if (!wait_first && solver_done) begin
                    capture    = 1'b1;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                pix_valid = 1'b1;
                if (pix_ready) begin
                    state_next = ADVANCE;
                end
            end
            ADVANCE: begin
                if (last) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end else begin
                    step       = 1'b1;
                    state_next = LAUNCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef PIXEL_DISPATCH_PERF_EN
    // Frame cycle counter: the accepting start cycle counts as the first cycle,
    // then one per busy cycle; holds in IDLE until the next start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cycles <= '0;
        end else if ((state == IDLE) && start) begin
            frame_cycles <= 32'd1;
        end else if (busy) begin
            frame_cycles <= frame_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Self-checking bench for pixel_dispatcher on a 4x2 frame with a
// behavioural solver that finishes on its 7th WAIT cycle and glitches
// solver_done (with a bogus count) on the first WAIT cycle.
module tb_pixel_dispatcher;
    import mandel_pkg::*;

    localparam int H   = 4;
    localparam int V   = 2;
    localparam int LAT = 7;

    logic  clk = 1'b0;
    logic  reset;
    logic  start;
    fix_t  x_start;
    fix_t  y_start;
    fix_t  dx;
    fix_t  dy;
    logic  solver_reset;
    fix_t  cr;
    fix_t  ci;
    iter_t solver_iter;
    logic  solver_done;
    logic  pix_valid;
    logic  pix_ready;
    addr_t pix_addr;
    iter_t pix_iter;
    logic  busy;
    logic  frame_done;
`ifdef PIXEL_DISPATCH_PERF_EN
    logic [31:0] frame_cycles;
`endif

    always #5 clk = ~clk;

    pixel_dispatcher #(
        .H_RES (H),
        .V_RES (V)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .x_start      (x_start),
        .y_start      (y_start),
        .dx           (dx),
        .dy           (dy),
        .solver_reset (solver_reset),
        .cr           (cr),
        .ci           (ci),
        .solver_iter  (solver_iter),
        .solver_done  (solver_done),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_addr     (pix_addr),
        .pix_iter     (pix_iter),
        .busy         (busy),
`ifdef PIXEL_DISPATCH_PERF_EN
        .frame_cycles (frame_cycles),
`endif
        .frame_done   (frame_done)
    );

    // Behavioural solver: counts cycles out of reset, done on count LAT-1,
    // plus a spurious done carrying count 99 on the first cycle out of reset.
    logic [7:0] scnt;
    always_ff @(posedge clk) begin
        if (solver_reset) scnt <= '0;
        else if (scnt != 8'hff) scnt <= scnt + 8'd1;
    end
    assign solver_done = !solver_reset && ((scnt == 8'(LAT - 1)) || (scnt == 8'd0));
    assign solver_iter = (scnt == 8'd0) ? 13'd99 : 13'd5;

    int n_cmp  = 0;
    int n_fail = 0;
    int fd_count = 0;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_count++;
    end

    typedef struct {
        addr_t addr;
        fix_t  cr;
        fix_t  ci;
    } pix_vec_t;

    pix_vec_t tab[8];

    function automatic fix_t to_fix(input real r);
        return fix_t'($rtoi(r * 8388608.0));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic cmp_pixel(input int k);
        check($sformatf("px%0d_addr", k), 32'(pix_addr), 32'(tab[k].addr));
        check($sformatf("px%0d_cr", k),   32'(cr),       32'(tab[k].cr));
        check($sformatf("px%0d_ci", k),   32'(ci),       32'(tab[k].ci));
        check($sformatf("px%0d_iter", k), 32'(pix_iter), 32'd5);
    endtask

    // Waits (bounded) for the next accepted pixel and compares it with the table.
    task automatic wait_pixel(input int k, output int gap);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(pix_valid && pix_ready) && n < 200);
        gap = n;
        if (!(pix_valid && pix_ready)) begin
            check($sformatf("px%0d_timeout", k), 32'd0, 32'd1);
        end else begin
            cmp_pixel(k);
        end
    endtask

    task automatic finish_frame(input int fd_expected);
        @(negedge clk);
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        @(negedge clk);
        check("frame_done_clear", 32'(frame_done), 32'd0);
        check("idle_after_frame", 32'(busy), 32'd0);
        check("frame_done_count", 32'(fd_count), 32'(fd_expected));
    endtask

    initial begin
        int    gap;
        int    n;
        int    sr_seen;
        logic  hold_ok;
        addr_t s_addr;
        iter_t s_iter;
        fix_t  s_cr;
        fix_t  s_ci;

        tab[0] = '{19'd0, to_fix(-2.0), to_fix(1.0)};
        tab[1] = '{19'd1, to_fix(-1.5), to_fix(1.0)};
        tab[2] = '{19'd2, to_fix(-1.0), to_fix(1.0)};
        tab[3] = '{19'd3, to_fix(-0.5), to_fix(1.0)};
        tab[4] = '{19'd4, to_fix(-2.0), to_fix(0.0)};
        tab[5] = '{19'd5, to_fix(-1.5), to_fix(0.0)};
        tab[6] = '{19'd6, to_fix(-1.0), to_fix(0.0)};
        tab[7] = '{19'd7, to_fix(-0.5), to_fix(0.0)};

        reset     = 1'b0;
        start     = 1'b0;
        pix_ready = 1'b1;
        x_start   = to_fix(-2.0);
        y_start   = to_fix(1.0);
        dx        = to_fix(0.5);
        dy        = to_fix(1.0);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",         32'(busy),         32'd0);
        check("rst_pix_valid",    32'(pix_valid),    32'd0);
        check("rst_frame_done",   32'(frame_done),   32'd0);
        check("rst_solver_reset", 32'(solver_reset), 32'd1);
        check("rst_addr",         32'(pix_addr),     32'd0);
        check("rst_cr",           32'(cr),           32'd0);
        check("rst_ci",           32'(ci),           32'd0);
        check("rst_iter",         32'(pix_iter),     32'd0);
`ifdef PIXEL_DISPATCH_PERF_EN
        check("rst_frame_cycles", frame_cycles,      32'd0);
`endif
        reset = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Frame 1: full raster, glitch ignored, throughput, start while busy ignored
        pulse_start();
        wait_pixel(0, gap);
        wait_pixel(1, gap);
        check("throughput_gap", 32'(gap), 32'(LAT + 3));
        wait_pixel(2, gap);
        pulse_start();
        for (int k = 3; k < 8; k++) wait_pixel(k, gap);
        finish_frame(1);
`ifdef PIXEL_DISPATCH_PERF_EN
        check("frame_cycles", frame_cycles, 32'd81);
        repeat (5) @(negedge clk);
        check("frame_cycles_hold", frame_cycles, 32'd81);
`endif

        // Frame 2: 20-cycle stall in EMIT on the first pixel
        pix_ready = 1'b0;
        pulse_start();
        n = 0;
        while (!pix_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid", 32'(pix_valid), 32'd1);
        s_addr  = pix_addr;
        s_iter  = pix_iter;
        s_cr    = cr;
        s_ci    = ci;
        hold_ok = 1'b1;
        sr_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (pix_valid !== 1'b1 || pix_addr !== s_addr || pix_iter !== s_iter ||
                cr !== s_cr || ci !== s_ci) hold_ok = 1'b0;
            if (solver_reset !== 1'b0) sr_seen++;
        end
        check("stall_hold", 32'(hold_ok), 32'd1);
        check("stall_no_solver_reset", 32'(sr_seen), 32'd0);
        pix_ready = 1'b1;
        cmp_pixel(0);
        for (int k = 1; k < 8; k++) wait_pixel(k, gap);
        finish_frame(2);

        // Frame 3: asynchronous reset while pixel 5 is in flight
        pulse_start();
        for (int k = 0; k < 5; k++) wait_pixel(k, gap);
        repeat (4) @(negedge clk);
        check("pre_rst_addr", 32'(pix_addr), 32'd5);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy",         32'(busy),         32'd0);
        check("mid_rst_pix_valid",    32'(pix_valid),    32'd0);
        check("mid_rst_frame_done",   32'(frame_done),   32'd0);
        check("mid_rst_solver_reset", 32'(solver_reset), 32'd1);
        check("mid_rst_addr",         32'(pix_addr),     32'd0);
        check("mid_rst_cr",           32'(cr),           32'd0);
        check("mid_rst_ci",           32'(ci),           32'd0);
        check("mid_rst_iter",         32'(pix_iter),     32'd0);
`ifdef PIXEL_DISPATCH_PERF_EN
        check("mid_rst_frame_cycles", frame_cycles,      32'd0);
`endif
        repeat (3) @(negedge clk);
        check("mid_rst_no_frame_done", 32'(fd_count), 32'd2);
        reset = 1'b1;

        // Frame 4: restart from pixel 0 after the abandoned frame
        pulse_start();
        for (int k = 0; k < 8; k++) wait_pixel(k, gap);
        finish_frame(3);
`ifdef PIXEL_DISPATCH_PERF_EN
        check("frame_cycles_f4", frame_cycles, 32'd81);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_dispatcher.md
PIXEL_DISPATCHER -- requirements
Module: pixel_dispatcher

Interface
REQ-001 Parameter: H_RES, default 640, pixel columns per frame.
REQ-002 Parameter: V_RES, default 480, pixel rows per frame.
REQ-003 Port: clk  input  1  sole clock; all logic on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  one-cycle pulse; begins a frame when idle.
REQ-006 Port: x_start, y_start  input  27 each  signed 4.23; cr of column 0, ci of row 0.
REQ-007 Port: dx, dy  input  27 each  signed 4.23; cr step per column, ci step per row.
REQ-008 Port: solver_reset  output  1  active-high synchronous reset to the iteration solver.
REQ-009 Port: cr, ci  output  27 each  signed 4.23 point under test.
REQ-010 Port: solver_iter  input  13  solver iteration count.
REQ-011 Port: solver_done  input  1  solver finished (diverged or hit max).
REQ-012 Port: pix_valid  output  1  result available to the VGA writer.
REQ-013 Port: pix_ready  input  1  VGA writer accepts result.
REQ-014 Port: pix_addr  output  19  linear address y*H_RES+x.
REQ-015 Port: pix_iter  output  13  captured iteration count.
REQ-016 Port: busy  output  1  high outside IDLE.
REQ-017 Port: frame_done  output  1  one-cycle pulse after last pixel accepted.

Function
REQ-018 FSM states SHALL be IDLE, LAUNCH, WAIT, EMIT, ADVANCE.
REQ-019 IDLE->LAUNCH on start; start SHALL be ignored in every other state; entering from IDLE latches x_start/y_start/dx/dy, sets x=y=0, pix_addr=0, cr=x_start, ci=y_start.
REQ-020 LAUNCH SHALL last exactly one cycle with solver_reset=1, then go to WAIT; solver_reset=0 in all other states except IDLE, where it SHALL be 1.
REQ-021 WAIT SHALL ignore solver_done on its first cycle, then on the first cycle solver_done=1 capture solver_iter into pix_iter and go to EMIT.
REQ-022 cr/ci SHALL remain constant from LAUNCH through end of EMIT.
REQ-023 EMIT SHALL hold pix_valid=1 with pix_addr/pix_iter stable until the cycle pix_valid&&pix_ready, then go to ADVANCE; pix_ready low stalls indefinitely.
REQ-024 ADVANCE, x<H_RES-1: x+=1, cr+=dx, pix_addr+=1, ->LAUNCH.
REQ-025 ADVANCE, x==H_RES-1 and y<V_RES-1: x=0, cr=x_start, y+=1, ci-=dy, pix_addr+=1, ->LAUNCH.
REQ-026 ADVANCE, last pixel: frame_done=1 that cycle, ->IDLE.
REQ-027 cr/ci accumulation SHALL be 27-bit two's-complement wrap, no saturation; no multipliers.
REQ-028 Throughput: one pixel per (solver latency + 3) cycles with pix_ready held high.

Reset
REQ-029 reset low SHALL, asynchronously, force IDLE and zero x, y, cr, ci, pix_addr, pix_iter, pix_valid, busy, frame_done; solver_reset=1.
REQ-030 Reset mid-frame SHALL abandon the frame with no frame_done; the next start restarts at pixel 0.

Configuration
REQ-031 Macro PIXEL_DISPATCH_PERF_EN defined: add output frame_cycles (32 bits), cleared on frame start, incremented each busy cycle, held after frame_done until next start; reset zero.
REQ-032 Macro undefined: no frame_cycles port and no counter logic.

Structure
REQ-033 Package mandel_pkg SHALL hold the 4.23 fixed-point typedef, iteration-count typedef, H_RES/V_RES defaults and the FSM state enum.
REQ-034 One sub-module, coord_stepper, SHALL hold x/y counters, cr/ci accumulators and pix_addr, driven by load/step strobes from the FSM.

Verification (H_RES=4, V_RES=2, behavioural solver model)
REQ-035 x_start=-2.0, y_start=1.0, dx=0.5, dy=1.0, start -> 8 pixels, addr 0..7, cr -2.0,-1.5,-1.0,-0.5 per row, ci 1.0 then 0.0, one frame_done.
REQ-036 Model returns iter 5 after 7 cycles, done glitch on WAIT first cycle -> glitch ignored, pix_iter=5.
REQ-037 pix_ready low 20 cycles in EMIT -> pix_valid, pix_addr, pix_iter, cr, ci held; no solver_reset.
REQ-038 start pulsed while busy -> ignored; addresses continue in sequence.
REQ-039 reset low at pixel 5 -> all outputs zero immediately, no frame_done; next start emits addr 0.
REQ-040 PIXEL_DISPATCH_PERF_EN defined, fixed 7-cycle solver, pix_ready high -> frame_cycles = 8*(7+3) +1 = 81.
